// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract unit: one SLICE-bit digit per clock through a
// full-adder ripple, with the carry registered between digits.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT             state;
    stateT             nextState;
    logic [WIDTH-1:0]  aReg;
    logic [WIDTH-1:0]  bReg;
    logic              carryReg;
    logic [CW-1:0]     sliceCnt;
    logic              lastSlice;
    logic [31:0]       shiftAmt;
    logic [WIDTH-1:0]  aShift;
    logic [WIDTH-1:0]  bShift;
    logic [SLICE-1:0]  sliceA;
    logic [SLICE-1:0]  sliceB;
    logic [SLICE-1:0]  digit;
    logic              ripple;
    logic              sliceCarry;
    logic [WIDTH-1:0]  nextSum;

    assign lastSlice = (sliceCnt == CW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid) nextState = BUSY;
            BUSY:    if (lastSlice) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Select the current digit by shifting, then ripple it through SLICE full-adder cells.
    always_comb begin
        shiftAmt = 32'(sliceCnt) * 32'(SLICE);
        aShift   = aReg >> shiftAmt;
        bShift   = bReg >> shiftAmt;
        sliceA   = aShift[SLICE-1:0];
        sliceB   = bShift[SLICE-1:0];
        digit    = '0;
        ripple   = carryReg;
        for (int i = 0; i < SLICE; i++) begin
            digit[i] = sliceA[i] ^ sliceB[i] ^ ripple;
            ripple   = (sliceA[i] & sliceB[i]) | (ripple & (sliceA[i] ^ sliceB[i]));
        end
        sliceCarry = ripple;
        nextSum    = (sum & ~(WIDTH'({SLICE{1'b1}}) << shiftAmt))
                   | (WIDTH'(digit) << shiftAmt);
    end

    // Subtract is folded in at acceptance: B and the carry are inverted once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aReg     <= '0;
            bReg     <= '0;
            carryReg <= 1'b0;
            sliceCnt <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aReg     <= a;
                        bReg     <= sub ? ~b : b;
                        carryReg <= sub ? ~c_in : c_in;
                        sliceCnt <= '0;
                    end
                end
                BUSY: begin
                    sum      <= nextSum;
                    carryReg <= sliceCarry;
                    sliceCnt <= sliceCnt + CW'(1);
                    if (lastSlice) begin
                        c_out <= sliceCarry;
                        ovf   <= (aReg[WIDTH-1] == bReg[WIDTH-1]) &&
                                 (nextSum[WIDTH-1] != aReg[WIDTH-1]);
                        zero  <= (nextSum == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: directed corner cases, back-pressure,
// asynchronous reset mid-operation and random ops against a reference model.
module tb_multicycle_adder;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cOut;
        logic             ovf;
        logic             zero;
    } expT;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    expT expQueue[$];
    int  checkCount = 0;
    int  errorCount = 0;

    multicycle_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic expT mkExp(input logic [WIDTH-1:0] s, input logic c,
                                  input logic o, input logic z);
        expT e;
        e.sum  = s;
        e.cOut = c;
        e.ovf  = o;
        e.zero = z;
        return e;
    endfunction

    function automatic expT refModel(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal,
                                     input logic cIn, input logic subVal);
        logic [WIDTH-1:0] bEff;
        logic             cEff;
        logic [WIDTH:0]   full;
        expT              e;
        bEff   = subVal ? ~bVal : bVal;
        cEff   = subVal ? ~cIn : cIn;
        full   = {1'b0, aVal} + {1'b0, bEff} + {{WIDTH{1'b0}}, cEff};
        e.sum  = full[WIDTH-1:0];
        e.cOut = full[WIDTH];
        e.ovf  = (aVal[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != aVal[WIDTH-1]);
        e.zero = (full[WIDTH-1:0] == '0);
        return e;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal,
                                 input logic cIn, input logic subVal, input expT expected);
        int waitCnt;
        @(negedge clk);
        a        = aVal;
        b        = bVal;
        c_in     = cIn;
        sub      = subVal;
        in_valid = 1'b1;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("acceptWait", 32'(waitCnt < 50), 32'd1);
        expQueue.push_back(expected);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        c_in     = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic collectResult(input int holdCycles);
        int  lat;
        expT e;
        lat = 0;
        while (!out_valid && lat < 4 * NSLICE + 10) begin
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        checkOutput("latency", 32'(lat), 32'(NSLICE));
        checkOutput("queueDepth", 32'(expQueue.size()), 32'd1);
        e = (expQueue.size() > 0) ? expQueue.pop_front() : '0;
        checkOutput("sum", 32'(sum), 32'(e.sum));
        checkOutput("c_out", 32'(c_out), 32'(e.cOut));
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
        checkOutput("zero", 32'(zero), 32'(e.zero));
        checkOutput("inReadyDone", 32'(in_ready), 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdReady", 32'(in_ready), 32'd0);
            checkOutput("holdSum", 32'(sum), 32'(e.sum));
            checkOutput("holdFlags", {29'd0, c_out, ovf, zero}, {29'd0, e.cOut, e.ovf, e.zero});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("validDrop", 32'(out_valid), 32'd0);
        checkOutput("readyBack", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] aVal;
        logic [WIDTH-1:0] bVal;
        logic             cIn;
        logic             subVal;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        #12;
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstSum", 32'(sum), 32'd0);
        checkOutput("rstFlags", {29'd0, c_out, ovf, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, mkExp(16'h8000, 1'b0, 1'b1, 1'b0));
        collectResult(0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, mkExp(16'h0000, 1'b1, 1'b0, 1'b1));
        collectResult(0);
        applyStimulus(16'h0005, 16'h0005, 1'b0, 1'b1, mkExp(16'h0000, 1'b1, 1'b0, 1'b1));
        collectResult(0);
        applyStimulus(16'h0003, 16'h0005, 1'b1, 1'b1, mkExp(16'hFFFD, 1'b0, 1'b0, 1'b0));
        collectResult(10);

        // Reset while the third digit is being processed.
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0, mkExp(16'hBCDE, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midRstInReady", 32'(in_ready), 32'd1);
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstSum", 32'(sum), 32'd0);
        checkOutput("midRstFlags", {29'd0, c_out, ovf, zero}, 32'd0);
        expQueue.delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, mkExp(16'h2345, 1'b0, 1'b0, 1'b0));
        collectResult(0);

        for (int n = 0; n < 300; n++) begin
            aVal   = WIDTH'($urandom);
            bVal   = WIDTH'($urandom);
            cIn    = 1'($urandom);
            subVal = 1'($urandom);
            if (n % 10 == 0) bVal = subVal ? aVal : ~aVal;
            applyStimulus(aVal, bVal, cIn, subVal, refModel(aVal, bVal, cIn, subVal));
            collectResult(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
